// File: rtl/sha_iterative_double_core_pkg.sv
// sha_iterative_double_core_pkg: SHA-256 state type, constants and round helper functions
package sha_iterative_double_core_pkg;
  typedef logic [0:7][31:0] hash_state_t;
  typedef enum logic [2:0] {IDLE, HASH1, PAD, HASH2, DONE} state_t;
  localparam hash_state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] k_const(input logic [5:0] i);
    return K_TABLE[i];
  endfunction
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
  function automatic hash_state_t add_state(input hash_state_t a, input hash_state_t b);
    hash_state_t s;
    for (int i = 0; i < 8; i++) s[i] = a[i] + b[i];
    return s;
  endfunction
endpackage

// File: rtl/sha_unrolled_round_group.sv
// sha_unrolled_round_group: R chained SHA-256 rounds plus the matching R-word schedule shift
module sha_unrolled_round_group
  import sha_iterative_double_core_pkg::*;
#(
  parameter int R = 1
) (
  input  hash_state_t       state,
  input  logic [15:0][31:0] w,
  input  logic [5:0]        base,
  output hash_state_t       next_state,
  output logic [15:0][31:0] next_w
);
  always_comb begin
    logic [31:0] ext [16+R];
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int i = 16; i < 16 + R; i++) ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
    for (int i = 0; i < 16; i++) next_w[i] = ext[i+R];
  end
  always_comb begin
    hash_state_t s;
    logic [31:0] t1, t2;
    s = state;
    t1 = '0;
    t2 = '0;
    for (int j = 0; j < R; j++) begin
      t1 = s[7] + bsig1(s[4]) + ch(s[4], s[5], s[6]) + k_const(base + 6'(j)) + w[j];
      t2 = bsig0(s[0]) + maj(s[0], s[1], s[2]);
      s = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
    end
    next_state = s;
  end
endmodule

// File: rtl/sha_iterative_double_core.sv
// sha_iterative_double_core: double SHA-256 of midstate+block, one shared R-round group iterated per hash
module sha_iterative_double_core
  import sha_iterative_double_core_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  hash_state_t       in_midstate,
  input  logic [15:0][31:0] in_block,
  output logic              out_valid,
  input  logic              out_ready,
  output hash_state_t       doublehash
);
  localparam logic [5:0] STEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST = 6'(64 - ROUNDS_PER_CYCLE);
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  state_t state, next;
  logic [5:0] cnt;
  logic last;
  hash_state_t work, mid, grp_state, first_hash;
  logic [15:0][31:0] win, grp_win, pad_win;
  assign last = cnt == LAST;
  assign first_hash = add_state(work, mid);
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = in_valid ? HASH1 : IDLE;
      HASH1:   next = last ? PAD : HASH1;
      PAD:     next = HASH2;
      HASH2:   next = last ? DONE : HASH2;
      DONE:    next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  sha_unrolled_round_group #(.R(ROUNDS_PER_CYCLE)) u_group (
    .state(work),
    .w(win),
    .base(cnt),
    .next_state(grp_state),
    .next_w(grp_win)
  );
  // second block: first digest, end-of-message bit, zero fill, 256-bit length
  always_comb begin
    pad_win = '0;
    for (int i = 0; i < 8; i++) pad_win[i] = first_hash[i];
    pad_win[8] = 32'h8000_0000;
    pad_win[15] = 32'd256;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      doublehash <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mid <= in_midstate;
          work <= in_midstate;
          win <= in_block;
          cnt <= '0;
        end
        HASH1, HASH2: begin
          work <= grp_state;
          win <= grp_win;
          cnt <= cnt + STEP;
          if (state == HASH2 && last) doublehash <= add_state(grp_state, IV);
        end
        PAD: begin
          work <= IV;
          win <= pad_win;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sha_iterative_double_core.md
# sha_iterative_double_core

Area-scalable double SHA-256 engine: accepts a 256-bit midstate plus one 512-bit message block and returns SHA256(SHA256(block | midstate)). Each hash is computed by re-using ROUNDS_PER_CYCLE unrolled rounds over 64/ROUNDS_PER_CYCLE cycles. It trades throughput for area against the fully pipelined core. It sits between the work dispatcher and the difficulty comparator and uses valid/ready handshakes on both sides, so it tolerates back-pressure.

## Interface
- ROUNDS_PER_CYCLE, default 1: SHA rounds evaluated per clock. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- clk  input  1: clock, rising edge.
- rst  input  1: synchronous, active-high reset.
- in_valid  input  1: a job is offered.
- in_ready  output  1: the core accepts a job this cycle.
- in_midstate  input  HashState (256): chaining state for the first hash.
- in_block  input  logic[15:0][31:0]: message words W0..W15; word 0 is the first word.
- out_valid  output  1: doublehash is valid.
- out_ready  input  1: the consumer takes the result.
- doublehash  output  HashState (256): final double hash.

## Operation
- FSM states: IDLE, HASH1, PAD, HASH2, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_midstate into the saved midstate register;
  - load the working state from in_midstate;
  - load the 16-word W window from in_block;
  - clear the round counter;
  - go to HASH1.
- HASH1 and HASH2:
  - Each cycle applies ROUNDS_PER_CYCLE rounds with K[r..r+R-1].
  - The W window shifts by R words. New words come from the standard σ0/σ1 expansion.
  - Rounds 0..15 consume the loaded words. Expansion results enter the window from the first cycle onward.
  - The counter advances by R. On the last group (counter = 64−R), go to the next state.
- PAD, one cycle:
  - firsthash = working state + saved midstate, per-word mod 2^32.
  - Load W = {firsthash H0..H7, 0x80000000, 0×6, 0x00000100}.
  - Load working state = SHA-256 initial hash.
  - Clear the counter and go to HASH2.
- HASH2 exit: register doublehash = working state + initial hash (per word mod 2^32), then go to DONE.
- DONE: out_valid=1 and doublehash held stable. On out_ready, go to IDLE.
- in_ready is 0 in every state except IDLE. in_valid outside IDLE is ignored; the source must hold it.
- All additions are 32-bit wrap-around, with no carry between words.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1 in the first cycle after reset release;
  - out_valid=0;
  - doublehash=0;
  - round counter=0.
- Let N = 64/ROUNDS_PER_CYCLE. For an accept at edge t:
  - HASH1 occupies cycles t+1..t+N;
  - PAD is cycle t+N+1;
  - HASH2 occupies t+N+2..t+2N+1;
  - out_valid rises at t+2N+2.
- Resulting latency is 2N+2: 130 for R=1, 34 for R=4, 10 for R=16.
- When out_valid and out_ready are both high at edge u, the core is in IDLE at u+1. The earliest next accept is edge u+1.
- Minimum initiation interval is 2N+3 cycles.
- Back-pressure: out_valid and doublehash stay constant for as long as out_ready=0.
- rst asserted in any state, mid-hash included, aborts the job. The next cycle is IDLE with out_valid=0. No partial result is ever presented.
- The critical path is R chained rounds. R=16 is a timing-exploration setting only.

## Structure
- Shared sha package holds:
  - the HashState typedef;
  - Kfunction(i);
  - the initial hash constant;
  - Σ0, Σ1, σ0, σ1, Ch, Maj functions;
  - a per-word hash-state add function.
- Combinational sub-module sha_unrolled_round_group #(R):
  - inputs: state, W window, base round index;
  - outputs: state after R rounds, and the W window shifted by R.
  - Both hashes use the same single instance.
- The top level holds only the FSM, round counter, and the registers for working state, W window, saved midstate and doublehash.

## Test plan
- Empty message, R=1: midstate = initial hash, block = {0x80000000, 0×15}. Required: doublehash = 5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456, with out_valid exactly 130 cycles after accept.
- "abc", R=4: midstate = initial hash, block = {0x61626380, 0×14, 0x00000018}. Required: 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358 at latency 34; also check R=16 at latency 10.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid rises. Required: doublehash is constant, in_ready=0 throughout, and the core releases one cycle after out_ready rises.
- Back-to-back: in_valid held high with two different jobs and out_ready tied to 1. Required: both results are correct, and the second accept occurs exactly 2N+3 cycles after the first.
- Reset mid-HASH2: assert rst for one cycle at round 40 of the second hash. Required: out_valid stays 0 and in_ready=1 the next cycle; a new job then produces the correct hash.
- Illegal parameter: R=3 must fail elaboration.
